// File: rtl/risc_toy_fetch_queue_if.sv
// Fetch-queue bus: instruction-memory port, redirect input and decode handshake.
// The master modport is the fetch queue; the slave modport is memory/EX/decode.
interface risc_toy_fetch_queue_if #(
  parameter int AW    = 30,
  parameter int DW    = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          ireq;
  logic [AW-1:0] iaddr;
  logic [DW-1:0] instr;
  logic          redir;
  logic [AW-1:0] redir_addr;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_instr;
  logic [AW-1:0] out_pc;
  logic [CW-1:0] count;

  modport master (
    output ireq, iaddr, out_valid, out_instr, out_pc, count,
    input  instr, redir, redir_addr, out_ready
  );

  modport slave (
    input  ireq, iaddr, out_valid, out_instr, out_pc, count,
    output instr, redir, redir_addr, out_ready
  );
endinterface

// File: rtl/risc_toy_fetch_queue.sv
// Instruction-fetch front end: issues 1-cycle-latency memory requests and queues
// returned words with their PCs for decode; a redirect flushes and refetches.
module risc_toy_fetch_queue #(
  parameter int            AW       = 30,
  parameter int            DW       = 32,
  parameter int            DEPTH    = 4,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  risc_toy_fetch_queue_if.master  bus
);
  localparam int            CW      = $clog2(DEPTH + 1);
  localparam int            PW      = $clog2(DEPTH);
  localparam logic [CW:0]   W_DEPTH = (CW + 1)'(DEPTH);

  logic          r_started;
  logic          r_pend;
  logic [AW-1:0] r_fetch_pc;
  logic [AW-1:0] r_pend_pc;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [DW-1:0] r_q_instr [DEPTH];
  logic [AW-1:0] r_q_pc    [DEPTH];

  logic [CW:0]   w_inflight;
  logic          w_issue;
  logic          w_valid;
  logic          w_pop;
  logic          w_push;

  // Credit counts queued entries plus the outstanding response; same-cycle pops
  // are deliberately not credited so IREQ never depends on OUT_READY.
  assign w_inflight = {1'b0, r_count} + {{CW{1'b0}}, r_pend};
  assign w_issue    = r_started & (w_inflight < W_DEPTH);
  assign w_valid    = (r_count != '0) & ~bus.redir;
  assign w_pop      = w_valid & bus.out_ready;
  assign w_push     = r_pend & ~bus.redir;

  assign bus.ireq      = bus.redir | w_issue;
  assign bus.iaddr     = bus.redir ? bus.redir_addr : r_fetch_pc;
  assign bus.out_valid = w_valid;
  assign bus.out_instr = r_q_instr[r_rd_ptr];
  assign bus.out_pc    = r_q_pc[r_rd_ptr];
  assign bus.count     = r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_started  <= 1'b0;
      r_pend     <= 1'b0;
      r_fetch_pc <= RESET_PC;
      r_pend_pc  <= RESET_PC;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else if (bus.redir) begin
      r_started  <= 1'b1;
      r_pend     <= 1'b1;
      r_pend_pc  <= bus.redir_addr;
      r_fetch_pc <= bus.redir_addr + AW'(1);
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_started <= 1'b1;
      if (w_issue) begin
        r_pend     <= 1'b1;
        r_pend_pc  <= r_fetch_pc;
        r_fetch_pc <= r_fetch_pc + AW'(1);
      end else begin
        r_pend <= 1'b0;
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Storage carries no reset; validity is tracked entirely by r_count.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_q_instr[r_wr_ptr] <= bus.instr;
      r_q_pc[r_wr_ptr]    <= r_pend_pc;
    end
  end
endmodule

// File: doc/risc_toy_fetch_queue.md
# risc_toy_fetch_queue

Parametrised instruction-fetch front end for the RISC_TOY pipeline. It drives the synchronous instruction-memory port (IREQ/IADDR/INSTR) and buffers returned words in a DEPTH-entry FIFO tagged with their PCs. It presents them to decode through a valid/ready handshake, which replaces the single-register IF stage and the global stall. It also supports branch/jump redirects that flush the queue and discard the in-flight response.

## Interface
- AW, 30: instruction word-address width (byte address = {IADDR, 2'b00}).
- DW, 32: instruction width.
- DEPTH, 4: queue entries; power of two, >= 2; full throughput requires DEPTH >= 3.
- RESET_PC, 0: word address of the first fetch after reset.
- CLK  in  1  clock; all state updates on rising edge.
- RSTN  in  1  asynchronous, active-low reset.
- IREQ  out  1  instruction-memory request this cycle.
- IADDR  out  AW  word address of the request.
- INSTR  in  DW  memory data for the request issued in the previous cycle.
- REDIR  in  1  single-cycle redirect pulse from EX (taken BR/BRL/J/JL).
- REDIR_ADDR  in  AW  redirect target word address.
- OUT_VALID  out  1  head entry valid.
- OUT_READY  in  1  decode accepts head entry.
- OUT_INSTR  out  DW  head instruction.
- OUT_PC  out  AW  word address of head instruction.
- COUNT  out  $clog2(DEPTH+1)  queue occupancy.

## Operation
- State: fetch_pc (AW), FIFO of {instr, pc} with wr/rd pointers (log2 DEPTH bits, natural wrap), count, pend (request issued last cycle), pend_pc, started.
- Memory contract: fixed 1-cycle latency; INSTR in cycle n+1 belongs to IADDR of cycle n when IREQ was 1.
- Issue rule (no redirect): IREQ = started & (count + pend < DEPTH). Pops in the current cycle are not credited. IADDR = fetch_pc. On issue, fetch_pc <= fetch_pc + 1 (mod 2^AW), pend <= 1, pend_pc <= fetch_pc.
- Response: if pend and no REDIR this cycle, write {INSTR, pend_pc} at wr pointer. The credit rule makes overflow impossible.
- Pop: OUT_VALID = (count != 0) & ~REDIR. Pop when OUT_VALID & OUT_READY. OUT_INSTR/OUT_PC are the head entry (don't-care when invalid).
- Simultaneous push and pop: count unchanged; both pointers advance.
- Redirect (REDIR = 1, takes priority over everything):
  - flush: count <= 0, pointers <= 0;
  - drop the response arriving this cycle;
  - IREQ = 1, IADDR = REDIR_ADDR;
  - fetch_pc <= REDIR_ADDR + 1, pend <= 1, pend_pc <= REDIR_ADDR;
  - OUT_READY is ignored and no pop occurs.
- REDIR while started = 0: same flush, and started <= 1.
- Wrap-around: fetch_pc and pend_pc roll from 2^AW-1 to 0 with no special action.

## Timing
- Reset values (asynchronous): started 0, fetch_pc RESET_PC, count 0, pointers 0, pend 0. Outputs: IREQ 0, IADDR RESET_PC, OUT_VALID 0, COUNT 0.
- Reset asserted mid-operation: all state returns to reset values immediately; any in-flight response is lost.
- First rising edge after RSTN deasserts: started <= 1. IREQ is 1 from the following cycle, with IADDR = RESET_PC.
- Fetch-to-decode latency: request in cycle n, write at the end of cycle n+1, OUT_VALID in cycle n+2.
- Redirect-to-valid: REDIR in cycle r gives OUT_VALID with OUT_PC = REDIR_ADDR in cycle r+2.
- Steady state with OUT_READY held at 1 and DEPTH >= 3: one instruction per cycle, COUNT settles at 1.
- With OUT_READY = 0: the queue fills to DEPTH, then IREQ drops. IREQ rises again in the cycle after the first pop.
- DEPTH = 2 with OUT_READY = 1: alternating bubble, throughput of 1 instruction per 2 cycles.

## Test plan
- Reset release, OUT_READY = 1, RESET_PC = 0, memory returns instr = addr ^ 32'hA5A5_0000 -> OUT_PC sequence 0, 1, 2, … on consecutive cycles starting 3 cycles after deassertion; COUNT stays 1.
- Backpressure: OUT_READY = 0 for 10 cycles, DEPTH = 4 -> COUNT reaches 4, IREQ = 0, no address skipped. Releasing OUT_READY delivers PCs in order with no duplicates.
- Redirect mid-stream: REDIR with REDIR_ADDR = 30'h100 while count = 3 and pend = 1 -> in the same cycle IREQ = 1, IADDR = 30'h100, OUT_VALID = 0. Next cycle COUNT = 0. The cycle after, OUT_PC = 30'h100, and no pre-redirect PC ever appears.
- REDIR with OUT_READY = 1 in the same cycle -> no pop is counted, queue is flushed, and the following stream starts exactly at REDIR_ADDR.
- Wrap: REDIR_ADDR = 2^AW - 2 -> OUT_PC sequence 3FFF_FFFE, 3FFF_FFFF, 0, 1 (AW = 30).
- RSTN pulsed low for one cycle with COUNT = 2 -> IREQ, OUT_VALID and COUNT are immediately 0, and fetch restarts at RESET_PC.
